bit_window_select_stream: RTL and testbench
===========================================

// Module: bit_window_select_stream
// PURPOSE
//  Parametrised sequential bit-window selector for the NoC utility library.
//  - Extracts an OUT_WIDTH-bit window from an IN_WIDTH-bit input beat; the command travels with each beat.
//  - Supports pass-through, clamped-offset and zero-padded-offset modes.
//  - Valid/ready handshake on both sides, through a 2-entry output skid FIFO, so the block can stall the NoC pipeline.
//  - Next generation of the fixed 8x4 selector; the output no longer depends combinationally on the command.
// PARAMETERS
//  IN_WIDTH      16                       input beat width, >= 2
//  OUT_WIDTH     8                        output window width, 1..IN_WIDTH
//  OFFSET_WIDTH  $clog2(IN_WIDTH)         width of the offset field
//  CMD_WIDTH     OFFSET_WIDTH+2           cmd = {mode[1:0], offset[OFFSET_WIDTH-1:0]}
// PORTS
//  clk         in   1              clock, all logic on posedge
//  rst         in   1              synchronous reset, active-low (0 = reset)
//  i_en        in   1              enable; 0 blocks acceptance, output side still drains
//  i_valid     in   1              upstream beat valid
//  i_data_bus  in   IN_WIDTH       upstream data
//  i_cmd       in   CMD_WIDTH      per-beat command, sampled with i_data_bus
//  o_ready     out  1              block can accept a beat this cycle
//  o_valid     out  1              output beat valid (head of FIFO)
//  o_data_bus  out  OUT_WIDTH      output window; all zeros when o_valid=0
//  i_ready     in   1              downstream accepts the beat
//  o_err       out  1              sticky error flag
// BEHAVIOUR
//  Reset (rst=0 at posedge): FIFO flushed, count=0.
//   o_valid=0, o_data_bus=0, o_err=0, o_ready=0 while rst=0.
//  Handshake:
//   - o_ready = rst & i_en & (count<2); combinational from the count register only.
//   - push = i_valid & o_ready; pop = o_valid & i_ready.
//   - Latency: a beat pushed at edge N is at the FIFO head after N when the FIFO was empty.
//   - Strict FIFO order. o_valid = (count!=0).
//  Count update:
//   - push & pop at count 1: count stays 1, new beat becomes head.
//   - At count 2: o_ready=0, so no push; a pop frees a slot on the next cycle.
//   - pop at count 0: impossible (o_valid=0).
//  Window computation, done before the FIFO write (registered data only):
//   - off = i_cmd[OFFSET_WIDTH-1:0], MAX = IN_WIDTH-OUT_WIDTH.
//   - mode 0 (pass): out = in[OUT_WIDTH-1:0], off ignored.
//   - mode 1 (clamp): out = in[off +: OUT_WIDTH] if off<=MAX.
//     Otherwise out = in[MAX +: OUT_WIDTH] and o_err is set.
//   - mode 2 (zero-pad): out[k] = (off+k < IN_WIDTH) ? in[off+k] : 0, for k in 0..OUT_WIDTH-1. No error.
//   - mode 3 (reserved): beat is consumed (push handshake completes) but not written to the FIFO. o_err is set.
//  o_err: sticky once set, cleared only by reset.
//   Set on the cycle after the offending push; it is never set on an unaccepted beat.
//  i_en=0: o_ready=0. Queued beats still drain with i_ready. No state is lost.
//  Reset mid-operation: all queued beats are discarded, no partial output.
//   Resumes accepting the first cycle with rst=1.
//  Unused FIFO entries hold zeros; no X may reach o_data_bus.
// TESTING (IN_WIDTH=16, OUT_WIDTH=8)
//  1. Pass: mode0, data 16'hA5C3, i_ready=1.
//     -> o_valid=1, o_data_bus=8'hC3 one cycle later; then o_valid=0, data 0.
//  2. Clamp: mode1 off=4, data 16'hA5C3 -> 8'h5C, o_err=0.
//     Then mode1 off=12 -> 8'hA5 (clamped to off 8), o_err=1 and stays 1.
//  3. Zero-pad: mode2 off=12, data 16'hA5C3 -> 8'h0A.
//     mode2 off=15, data 16'h8000 -> 8'h01.
//  4. Backpressure: i_ready=0, offer 3 beats (mode0: 16'h0011, 16'h0022, 16'h0033).
//     -> o_ready=0 after 2 pushes. Raise i_ready -> outputs 11, 22, 33 in order, no loss or duplication.
//  5. Reserved/enable: mode3 beat -> accepted, no output, o_err=1.
//     i_en=0 with i_valid=1 -> o_ready=0, nothing queued.
//  6. Reset mid-stream: FIFO holding 2 beats, rst=0 for 1 cycle.
//     -> o_valid=0, o_err=0. Next push yields its data after 1 cycle.

Source files
------------

// File: rtl/bit_window_select_stream.sv
// bit_window_select_stream: per-beat commanded bit-window extraction from an IN_WIDTH beat,
// buffered through a 2-entry skid FIFO with valid/ready on both sides and a sticky error flag.
module bit_window_select_stream #(
    parameter int IN_WIDTH     = 16,
    parameter int OUT_WIDTH    = 8,
    parameter int OFFSET_WIDTH = $clog2(IN_WIDTH),
    parameter int CMD_WIDTH    = OFFSET_WIDTH + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic [IN_WIDTH-1:0]  i_data_bus,
    input  logic [CMD_WIDTH-1:0] i_cmd,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [OUT_WIDTH-1:0] o_data_bus,
    input  logic                 i_ready,
    output logic                 o_err
);
    localparam logic [OFFSET_WIDTH-1:0] MAX_OFF = OFFSET_WIDTH'(IN_WIDTH - OUT_WIDTH);

    logic [1:0]                    w_mode;
    logic [OFFSET_WIDTH-1:0]       w_off;
    logic                          w_over;
    logic [OFFSET_WIDTH-1:0]       w_shift;
    logic [IN_WIDTH+OUT_WIDTH-1:0] w_ext;
    logic [IN_WIDTH+OUT_WIDTH-1:0] w_shifted;
    logic [OUT_WIDTH-1:0]          w_win;
    logic                          w_push;
    logic                          w_write;
    logic                          w_pop;
    logic                          w_err_set;

    logic [OUT_WIDTH-1:0] r_mem [2];
    logic                 r_rd_ptr;
    logic                 r_wr_ptr;
    logic [1:0]           r_count;
    logic                 r_err;

    assign w_mode  = i_cmd[CMD_WIDTH-1 -: 2];
    assign w_off   = i_cmd[OFFSET_WIDTH-1:0];
    assign w_over  = w_off > MAX_OFF;
    assign w_shift = (w_mode == 2'd0) ? '0 : ((w_mode == 2'd1) && w_over) ? MAX_OFF : w_off;

    // Zero-extension above the beat supplies the zero padding for windows running off the top.
    assign w_ext     = {{OUT_WIDTH{1'b0}}, i_data_bus};
    assign w_shifted = w_ext >> w_shift;
    assign w_win     = w_shifted[OUT_WIDTH-1:0];

    assign o_ready   = rst & i_en & (r_count < 2'd2);
    assign o_valid   = (r_count != 2'd0);
    assign o_data_bus = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_err     = r_err;

    assign w_push    = i_valid & o_ready;
    assign w_write   = w_push & (w_mode != 2'd3);
    assign w_pop     = o_valid & i_ready;
    assign w_err_set = w_push & ((w_mode == 2'd3) | ((w_mode == 2'd1) & w_over));

    // Popped entries are cleared so idle slots always hold zeros.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_mem[r_rd_ptr] <= '0;
                r_rd_ptr        <= ~r_rd_ptr;
            end
            if (w_write) begin
                r_mem[r_wr_ptr] <= w_win;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            r_count <= r_count + 2'(w_write) - 2'(w_pop);
            r_err   <= r_err | w_err_set;
        end
    end
endmodule

// File: tb/tb_bit_window_select_stream.sv
// tb_bit_window_select_stream: directed scenarios plus randomized traffic against a queue-based
// reference model of the window selector and its 2-deep output buffer.
module tb_bit_window_select_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_en = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_data_bus = '0;
    logic [5:0]  i_cmd = '0;
    logic        i_ready = 1'b0;
    logic        o_ready;
    logic        o_valid;
    logic [7:0]  o_data_bus;
    logic        o_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_q[$];
    bit         m_err = 1'b0;

    bit_window_select_stream #(.IN_WIDTH(16), .OUT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_data_bus(i_data_bus),
        .i_cmd(i_cmd), .o_ready(o_ready), .o_valid(o_valid), .o_data_bus(o_data_bus),
        .i_ready(i_ready), .o_err(o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_win(logic [15:0] d, logic [1:0] m, int off);
        int         base;
        logic [7:0] r;
        base = (m == 2'd0) ? 0 : ((m == 2'd1) && (off > 8)) ? 8 : off;
        for (int k = 0; k < 8; k++) r[k] = (base + k < 16) ? d[base + k] : 1'b0;
        return r;
    endfunction

    task automatic set_in(bit v, logic [15:0] d, logic [1:0] m, logic [3:0] off, bit en, bit rdy);
        i_valid = v;
        i_data_bus = d;
        i_cmd = {m, off};
        i_en = en;
        i_ready = rdy;
        #1;
    endtask

    // Advances one clock and updates the reference model from the inputs held at the edge.
    task automatic step();
        bit rdy_e, push, pop;
        rdy_e = rst && i_en && (m_q.size() < 2);
        push = i_valid && rdy_e;
        pop = (m_q.size() != 0) && i_ready;
        @(posedge clk);
        if (!rst) begin
            m_q.delete();
            m_err = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (i_cmd[5:4] == 2'd3) m_err = 1'b1;
                else begin
                    m_q.push_back(ref_win(i_data_bus, i_cmd[5:4], int'(i_cmd[3:0])));
                    if ((i_cmd[5:4] == 2'd1) && (i_cmd[3:0] > 4'd8)) m_err = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(1, 16'hFFFF, 2'd0, 4'd0, 1, 1);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", o_ready); end
        step();
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", o_valid); end
        checks++; if (o_data_bus !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", o_data_bus); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", o_err); end
        rst = 1'b1;
        set_in(0, 16'h0, 2'd0, 4'd0, 1, 1);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b exp 1", o_ready); end
    endtask

    task automatic test_pass();
        set_in(1, 16'hA5C3, 2'd0, 4'd7, 1, 1);
        step();
        set_in(0, 16'h0, 2'd0, 4'd0, 1, 1);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL pass_valid: got %b exp 1", o_valid); end
        checks++; if (o_data_bus !== 8'hC3) begin errors++; $display("FAIL pass_data: got %h exp c3", o_data_bus); end
        step();
        checks++; if (o_valid !== 1'b0 || o_data_bus !== 8'h00) begin errors++; $display("FAIL pass_drain: got %b/%h exp 0/00", o_valid, o_data_bus); end
    endtask

    task automatic test_clamp();
        set_in(1, 16'hA5C3, 2'd1, 4'd4, 1, 1);
        step();
        set_in(1, 16'hA5C3, 2'd1, 4'd12, 1, 1);
        checks++; if (o_data_bus !== 8'h5C) begin errors++; $display("FAIL clamp_in_range: got %h exp 5c", o_data_bus); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL clamp_no_err: got %b exp 0", o_err); end
        step();
        set_in(0, 16'h0, 2'd0, 4'd0, 1, 1);
        checks++; if (o_data_bus !== 8'hA5) begin errors++; $display("FAIL clamp_over: got %h exp a5", o_data_bus); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL clamp_err_set: got %b exp 1", o_err); end
        step();
        step();
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL clamp_err_sticky: got %b exp 1", o_err); end
    endtask

    task automatic test_zeropad();
        set_in(1, 16'hA5C3, 2'd2, 4'd12, 1, 1);
        step();
        set_in(1, 16'h8000, 2'd2, 4'd15, 1, 1);
        checks++; if (o_data_bus !== 8'h0A) begin errors++; $display("FAIL zpad_off12: got %h exp 0a", o_data_bus); end
        step();
        set_in(0, 16'h0, 2'd0, 4'd0, 1, 1);
        checks++; if (o_data_bus !== 8'h01) begin errors++; $display("FAIL zpad_off15: got %h exp 01", o_data_bus); end
        step();
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        bit         pend, acc;
        set_in(1, 16'h0011, 2'd0, 4'd0, 1, 0);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b exp 1", o_ready); end
        step();
        set_in(1, 16'h0022, 2'd0, 4'd0, 1, 0);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b exp 1", o_ready); end
        step();
        set_in(1, 16'h0033, 2'd0, 4'd0, 1, 0);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b exp 0", o_ready); end
        step();
        checks++; if (o_valid !== 1'b1 || o_data_bus !== 8'h11) begin errors++; $display("FAIL bp_head_held: got %b/%h exp 1/11", o_valid, o_data_bus); end
        pend = 1'b1;
        for (int c = 0; c < 8; c++) begin
            set_in(pend, 16'h0033, 2'd0, 4'd0, 1, 1);
            if (o_valid) got.push_back(o_data_bus);
            acc = pend && o_ready;
            step();
            if (acc) pend = 1'b0;
        end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d exp 3", got.size()); end
        else begin
            checks++; if (got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin errors++; $display("FAIL bp_order: got %h %h %h exp 11 22 33", got[0], got[1], got[2]); end
        end
    endtask

    task automatic test_reserved_enable();
        rst = 1'b0;
        set_in(0, 16'h0, 2'd0, 4'd0, 1, 1);
        step();
        rst = 1'b1;
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rsv_pre_err: got %b exp 0", o_err); end
        set_in(1, 16'h1234, 2'd3, 4'd0, 1, 1);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rsv_ready: got %b exp 1", o_ready); end
        step();
        set_in(1, 16'h00AB, 2'd0, 4'd0, 0, 1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rsv_no_output: got %b exp 0", o_valid); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL rsv_err: got %b exp 1", o_err); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL en_low_ready: got %b exp 0", o_ready); end
        step();
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL en_low_nothing_queued: got %b exp 0", o_valid); end
        set_in(0, 16'h0, 2'd0, 4'd0, 1, 1);
    endtask

    task automatic test_reset_midstream();
        set_in(1, 16'h0044, 2'd0, 4'd0, 1, 0);
        step();
        set_in(1, 16'h0055, 2'd0, 4'd0, 1, 0);
        step();
        set_in(0, 16'h0, 2'd0, 4'd0, 1, 0);
        checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got %b/%b exp 1/0", o_valid, o_ready); end
        rst = 1'b0;
        set_in(1, 16'h0077, 2'd0, 4'd0, 1, 1);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b exp 0", o_ready); end
        step();
        rst = 1'b1;
        set_in(1, 16'h1111, 2'd3, 4'd0, 0, 1);
        checks++; if (o_valid !== 1'b0 || o_data_bus !== 8'h00) begin errors++; $display("FAIL mid_flush: got %b/%h exp 0/00", o_valid, o_data_bus); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL mid_err_clr: got %b exp 0", o_err); end
        step();
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL unaccepted_no_err: got %b exp 0", o_err); end
        set_in(1, 16'h0066, 2'd0, 4'd0, 1, 1);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mid_resume_ready: got %b exp 1", o_ready); end
        step();
        set_in(0, 16'h0, 2'd0, 4'd0, 1, 1);
        checks++; if (o_valid !== 1'b1 || o_data_bus !== 8'h66) begin errors++; $display("FAIL mid_resume_data: got %b/%h exp 1/66", o_valid, o_data_bus); end
        step();
    endtask

    task automatic test_random();
        bit         exp_rdy;
        logic [7:0] exp_data;
        logic [1:0] m;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) != 0);
            m = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            set_in(bit'($urandom_range(0, 1)), 16'($urandom), m, 4'($urandom),
                   ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0));
            exp_rdy = rst && i_en && (m_q.size() < 2);
            exp_data = (m_q.size() != 0) ? m_q[0] : 8'h00;
            checks++; if (o_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, o_ready, exp_rdy); end
            checks++; if (o_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b exp %b", c, o_valid, m_q.size() != 0); end
            checks++; if (o_data_bus !== exp_data) begin errors++; $display("FAIL rnd_data c%0d: got %h exp %h", c, o_data_bus, exp_data); end
            checks++; if (o_err !== m_err) begin errors++; $display("FAIL rnd_err c%0d: got %b exp %b", c, o_err, m_err); end
            step();
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_clamp();
        test_zeropad();
        test_backpressure();
        test_reserved_enable();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
